rx_window_ctrl: RTL and testbench

- Receive-side sequencer sitting directly downstream of the oversampling sampler.
- After the transmit path signals end of a reader command, it waits a guard time, then opens a receive window and hunts for a fixed preamble in the sampled stream.
- On a preamble match it forwards exactly rx_len sampled bits to the decoder as a framed stream; if no preamble arrives in time it reports a timeout.
- Also counts sample strobes to enforce link timing (guard and timeout).

---
 rtl/rfid_rx_pkg.sv | 27 ++
 rtl/rx_window_ctrl_preamble_det.sv | 59 +++++
 rtl/rx_window_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_rx_window_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rfid_rx_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : rfid_rx_pkg
//  Description : Shared receive-path types and link constants (state enum,
//                default preamble, length field width).
//  Revision    : 1.0  initial release
// ============================================================================
package rfid_rx_pkg;

  // Receive sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_HUNT  = 2'd2,
    ST_RECV  = 2'd3
  } rx_state_t;

  // Preamble shared with the TX encoder and the decoder; MSB is the oldest sample
  localparam int                     PRE_LEN_DEF  = 6;
  localparam logic [PRE_LEN_DEF-1:0] PREAMBLE_DEF = 6'b110100;

  // Width of the payload bit-count field
  localparam int                     LEN_W_DEF    = 8;

endpackage : rfid_rx_pkg
`default_nettype wire

// File: rtl/rx_window_ctrl_preamble_det.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : preamble_det
//  Description : Sliding preamble detector. Shifts one sample per shift_en,
//                tracks how many valid samples are held, and flags a match on
//                the shifting cycle using the window that includes the new
//                sample.
//  Revision    : 1.0  initial release
// ============================================================================
module preamble_det
  import rfid_rx_pkg::*;
#(
  parameter int                 PRE_LEN  = PRE_LEN_DEF,
  parameter logic [PRE_LEN-1:0] PREAMBLE = PREAMBLE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic shift_en,
  input  logic din,
  output logic match
);

  localparam int c_fill_w = $clog2(PRE_LEN + 1);

  logic [PRE_LEN-1:0]  r_shift;
  logic [PRE_LEN-1:0]  w_shift_nxt;
  logic [c_fill_w-1:0] r_fill;

  // Window as it will look once the current sample is shifted in
  generate
    if (PRE_LEN == 1) begin : g_single
      assign w_shift_nxt = din;
    end else begin : g_multi
      assign w_shift_nxt = {r_shift[PRE_LEN-2:0], din};
    end
  endgenerate

  // Shift register and saturating fill counter; clr restarts the hunt
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_shift <= '0;
      r_fill  <= '0;
    end else if (shift_en) begin
      r_shift <= w_shift_nxt;
      if (r_fill != c_fill_w'(PRE_LEN)) begin
        r_fill <= r_fill + c_fill_w'(1);
      end
    end
  end

  // Match needs a full window of post-clear samples, counting the new one
  assign match = shift_en
               && (w_shift_nxt == PREAMBLE)
               && (r_fill >= c_fill_w'(PRE_LEN - 1));

endmodule : preamble_det
`default_nettype wire

// File: rtl/rx_window_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : rx_window_ctrl
//  Description : Receive-window sequencer. After start it skips a guard time,
//                hunts for the preamble, then forwards rx_len sampled bits as
//                a framed stream, or reports a timeout if no preamble shows up.
//  Revision    : 1.0  initial release
// ============================================================================
module rx_window_ctrl
  import rfid_rx_pkg::*;
#(
  parameter int                 GUARD_SMP   = 8,
  parameter int                 TIMEOUT_SMP = 200,
  parameter int                 PRE_LEN     = PRE_LEN_DEF,
  parameter logic [PRE_LEN-1:0] PREAMBLE    = PREAMBLE_DEF,
  parameter int                 LEN_W       = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] rx_len,
  input  logic             in_dat,
  input  logic             in_vld,
  output logic             busy,
  output logic             win_open,
  output logic             bit_dat,
  output logic             bit_vld,
  output logic             bit_last,
  output logic             done,
  output logic             timeout
);

  localparam int                  c_tcnt_w = $clog2(TIMEOUT_SMP + 1);
  localparam logic [c_tcnt_w-1:0] c_guard  = c_tcnt_w'(GUARD_SMP);
  localparam logic [c_tcnt_w-1:0] c_tmo    = c_tcnt_w'(TIMEOUT_SMP);

  rx_state_t           r_state, w_state_nxt;
  logic [c_tcnt_w-1:0] r_tcnt, w_tcnt_nxt, w_tcnt_inc;
  logic [LEN_W-1:0]    r_len, w_len_nxt;
  logic [LEN_W-1:0]    r_bcnt, w_bcnt_nxt, w_bcnt_inc;
  logic                r_bit_dat, w_bit_dat_nxt;
  logic                r_bit_vld, w_bit_vld_nxt;
  logic                r_bit_last, w_bit_last_nxt;
  logic                r_done, w_done_nxt;
  logic                r_timeout, w_timeout_nxt;
  logic                w_pulse_pending;
  logic                w_det_clr;
  logic                w_det_shift;
  logic                w_match;

  // A done/timeout pulse on the outputs means the frame is over; the state
  // leaves for IDLE only after the pulse so a start in that cycle is ignored.
  assign w_pulse_pending = r_done || r_timeout;

  // Detector is cleared on every accepted start and only fed during HUNT
  assign w_det_clr   = (r_state == ST_IDLE) && start && !abort;
  assign w_det_shift = (r_state == ST_HUNT) && in_vld && !abort && !w_pulse_pending;

  // Sample counter saturates at the timeout value instead of wrapping
  assign w_tcnt_inc = (r_tcnt == c_tmo) ? r_tcnt : r_tcnt + c_tcnt_w'(1);
  assign w_bcnt_inc = r_bcnt + LEN_W'(1);

  preamble_det #(
    .PRE_LEN  (PRE_LEN),
    .PREAMBLE (PREAMBLE)
  ) u_preamble_det (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_det_clr),
    .shift_en (w_det_shift),
    .din      (in_dat),
    .match    (w_match)
  );

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_tcnt     <= '0;
      r_len      <= '0;
      r_bcnt     <= '0;
      r_bit_dat  <= 1'b0;
      r_bit_vld  <= 1'b0;
      r_bit_last <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tcnt     <= w_tcnt_nxt;
      r_len      <= w_len_nxt;
      r_bcnt     <= w_bcnt_nxt;
      r_bit_dat  <= w_bit_dat_nxt;
      r_bit_vld  <= w_bit_vld_nxt;
      r_bit_last <= w_bit_last_nxt;
      r_done     <= w_done_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  // Next-state and next-output decode; abort overrides everything
  always_comb begin
    w_state_nxt    = r_state;
    w_tcnt_nxt     = r_tcnt;
    w_len_nxt      = r_len;
    w_bcnt_nxt     = r_bcnt;
    w_bit_dat_nxt  = 1'b0;
    w_bit_vld_nxt  = 1'b0;
    w_bit_last_nxt = 1'b0;
    w_done_nxt     = 1'b0;
    w_timeout_nxt  = 1'b0;

    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_nxt = ST_GUARD;
            w_len_nxt   = rx_len;
            w_tcnt_nxt  = '0;
          end
        end

        ST_GUARD: begin
          // Samples are counted but their data is thrown away
          if (in_vld) begin
            w_tcnt_nxt = w_tcnt_inc;
          end
          if (r_tcnt == c_guard) begin
            w_state_nxt = ST_HUNT;
          end
        end

        ST_HUNT: begin
          if (w_pulse_pending) begin
            w_state_nxt = ST_IDLE;
          end else if (in_vld) begin
            w_tcnt_nxt = w_tcnt_inc;
            // A match on the timeout sample still wins
            if (w_match) begin
              if (r_len == '0) begin
                w_done_nxt = 1'b1;
              end else begin
                w_state_nxt = ST_RECV;
                w_bcnt_nxt  = '0;
              end
            end else if (w_tcnt_inc == c_tmo) begin
              w_timeout_nxt = 1'b1;
            end
          end
        end

        ST_RECV: begin
          if (w_pulse_pending) begin
            w_state_nxt = ST_IDLE;
          end else if (in_vld) begin
            w_bit_vld_nxt = 1'b1;
            w_bit_dat_nxt = in_dat;
            w_bcnt_nxt    = w_bcnt_inc;
            if (w_bcnt_inc == r_len) begin
              w_bit_last_nxt = 1'b1;
              w_done_nxt     = 1'b1;
            end
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = (r_state != ST_IDLE);
  assign win_open = (r_state == ST_HUNT) || (r_state == ST_RECV);
  assign bit_dat  = r_bit_dat;
  assign bit_vld  = r_bit_vld;
  assign bit_last = r_bit_last;
  assign done     = r_done;
  assign timeout  = r_timeout;

endmodule : rx_window_ctrl
`default_nettype wire

// File: tb/tb_rx_window_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_rx_window_ctrl
//  Description : Self-checking bench for rx_window_ctrl: directed table,
//                hand-written corner sequences and randomized frames checked
//                against a frame-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rx_window_ctrl;

  localparam int           GUARD_SMP   = 8;
  localparam int           TIMEOUT_SMP = 200;
  localparam int           PRE_LEN     = 6;
  localparam logic [5:0]   PREAMBLE    = 6'b110100;
  localparam int           LEN_W       = 8;
  localparam int           SMP_MAX     = 260;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [LEN_W-1:0] rx_len = '0;
  logic             in_dat = 1'b0;
  logic             in_vld = 1'b0;
  logic             busy, win_open, bit_dat, bit_vld, bit_last, done, timeout;

  rx_window_ctrl #(
    .GUARD_SMP   (GUARD_SMP),
    .TIMEOUT_SMP (TIMEOUT_SMP),
    .PRE_LEN     (PRE_LEN),
    .PREAMBLE    (PREAMBLE),
    .LEN_W       (LEN_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .rx_len   (rx_len),
    .in_dat   (in_dat),
    .in_vld   (in_vld),
    .busy     (busy),
    .win_open (win_open),
    .bit_dat  (bit_dat),
    .bit_vld  (bit_vld),
    .bit_last (bit_last),
    .done     (done),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Sample stream of the current frame (index 0 = first strobe after start)
  bit smp[$];
  bit exp_q[$];
  int strobe_cyc[$];

  // Observed output events, stamped with the cycle they were seen in
  int mon_cyc[$];
  bit mon_dat[$];
  int mon_last[$];
  int mon_done[$];
  int mon_tmo[$];

  always @(negedge clk) begin
    if (bit_vld === 1'b1) begin
      mon_cyc.push_back(cyc);
      mon_dat.push_back(bit_dat);
    end
    if (bit_last === 1'b1) mon_last.push_back(cyc);
    if (done === 1'b1)     mon_done.push_back(cyc);
    if (timeout === 1'b1)  mon_tmo.push_back(cyc);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    int          len;
    int          pre_end;   // strobe number of the last preamble sample, 0 = none
    logic [15:0] pay;       // payload, first transmitted bit is pay[len-1]
    int          nsmp;
    int          nbits;     // expected payload bits
    bit          e_done;
    bit          e_tmo;
    int          e_end;     // strobe number that triggers done/timeout
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit d, input int gap);
    in_vld = 1'b1;
    in_dat = d;
    strobe_cyc.push_back(cyc);
    tick();
    in_vld = 1'b0;
    in_dat = 1'($urandom_range(0, 1));
    repeat (gap - 1) tick();
  endtask

  task automatic begin_frame(input int len);
    mon_cyc.delete(); mon_dat.delete(); mon_last.delete();
    mon_done.delete(); mon_tmo.delete(); strobe_cyc.delete();
    start  = 1'b1;
    rx_len = LEN_W'(len);
    tick();
    start  = 1'b0;
    tick();
  endtask

  task automatic end_frame();
    repeat (4) tick();
  endtask

  task automatic run_frame(input int len, input int nsmp, input int gap);
    begin_frame(len);
    for (int i = 0; i < nsmp; i++) send(smp[i], gap);
    end_frame();
  endtask

  // Zero-filled stream with an optional preamble and payload placed in it
  task automatic load_frame(input int pre_end, input int len, input logic [15:0] pay);
    smp.delete();
    for (int i = 0; i < SMP_MAX; i++) smp.push_back(1'b0);
    if (pre_end > 0) begin
      for (int j = 0; j < PRE_LEN; j++) smp[pre_end - PRE_LEN + j] = PREAMBLE[PRE_LEN-1-j];
      for (int j = 0; j < len && j < 16; j++) smp[pre_end + j] = pay[len-1-j];
    end
  endtask

  // Frame-level reference: first window of PRE_LEN hunt-phase samples equal to
  // the preamble at or before strobe TIMEOUT_SMP; payload is the next len samples.
  task automatic model(input int len, output int e_end, output bit e_done, output bit e_tmo);
    int               m;
    logic [PRE_LEN-1:0] w;
    m = 0;
    exp_q.delete();
    for (int k = GUARD_SMP + PRE_LEN; k <= TIMEOUT_SMP && m == 0; k++) begin
      for (int j = 0; j < PRE_LEN; j++) w[PRE_LEN-1-j] = smp[k-PRE_LEN+j];
      if (w == PREAMBLE) m = k;
    end
    if (m != 0) begin
      e_done = 1'b1;
      e_tmo  = 1'b0;
      e_end  = m + len;
      for (int j = 0; j < len; j++) exp_q.push_back(smp[m + j]);
    end else begin
      e_done = 1'b0;
      e_tmo  = 1'b1;
      e_end  = TIMEOUT_SMP;
    end
  endtask

  task automatic check_frame(input string tag, input int e_end, input bit e_done, input bit e_tmo);
    int n;
    int base;
    int pcyc;
    n    = exp_q.size();
    base = e_end - n;
    chk({tag, ".nbits"}, mon_dat.size(), n);
    if (e_end < 1 || e_end > strobe_cyc.size()) begin
      n_vec++;
      n_err++;
      $display("FAIL %s.strobes: got %0d strobes, required at least %0d", tag, strobe_cyc.size(), e_end);
      return;
    end
    pcyc = strobe_cyc[e_end-1] + 1;
    for (int i = 0; i < n && i < mon_dat.size(); i++) begin
      chk($sformatf("%s.bit%0d", tag, i), mon_dat[i], exp_q[i]);
      chk($sformatf("%s.bitcyc%0d", tag, i), mon_cyc[i], strobe_cyc[base + i] + 1);
    end
    chk({tag, ".nlast"}, mon_last.size(), (n > 0) ? 1 : 0);
    if (n > 0 && mon_last.size() == 1) chk({tag, ".lastcyc"}, mon_last[0], pcyc);
    chk({tag, ".ndone"}, mon_done.size(), e_done ? 1 : 0);
    if (e_done && mon_done.size() == 1) chk({tag, ".donecyc"}, mon_done[0], pcyc);
    chk({tag, ".ntmo"}, mon_tmo.size(), e_tmo ? 1 : 0);
    if (e_tmo && mon_tmo.size() == 1) chk({tag, ".tmocyc"}, mon_tmo[0], pcyc);
    chk({tag, ".idle"}, {busy, win_open}, 2'b00);
  endtask

  initial begin
    int e_end;
    bit e_done, e_tmo;
    int len, gap, dens, p;
    bit b;

    //          name             len pre  pay        nsmp nbits done tmo end
    tbl[0] = '{"basic",          4,  14,  16'h000B,  20,  4,    1,   0,  18};
    tbl[1] = '{"pre_in_guard",   4,  8,   16'h0000,  202, 0,    0,   1,  200};
    tbl[2] = '{"pre_at_200",     3,  200, 16'h0005,  205, 3,    1,   0,  203};
    tbl[3] = '{"pre_200_len0",   0,  200, 16'h0000,  202, 0,    1,   0,  200};
    tbl[4] = '{"len0_early",     0,  14,  16'h0000,  16,  0,    1,   0,  14};
    tbl[5] = '{"pre_straddle",   4,  13,  16'h0000,  202, 0,    0,   1,  200};
    tbl[6] = '{"pre_at_201",     2,  201, 16'h0000,  203, 0,    0,   1,  200};
    tbl[7] = '{"len16",          16, 20,  16'hA5C3,  40,  16,   1,   0,  36};
    tbl[8] = '{"len1",           1,  14,  16'h0000,  18,  1,    1,   0,  15};

    // Reset values while rst is held
    repeat (3) tick();
    chk("rst.outputs", {busy, win_open, bit_dat, bit_vld, bit_last, done, timeout}, 7'b0);
    rst = 1'b0;
    tick();
    chk("rst.release", {busy, win_open, bit_dat, bit_vld, bit_last, done, timeout}, 7'b0);

    // in_vld in IDLE does nothing
    send(1'b1, 2);
    chk("idle.strobe", {busy, bit_vld, done, timeout}, 4'b0);

    // Directed table
    for (int t = 0; t < 9; t++) begin
      load_frame(tbl[t].pre_end, tbl[t].len, tbl[t].pay);
      exp_q.delete();
      for (int j = 0; j < tbl[t].nbits; j++) exp_q.push_back(tbl[t].pay[tbl[t].nbits-1-j]);
      run_frame(tbl[t].len, tbl[t].nsmp, 2 + (t % 3));
      check_frame(tbl[t].name, tbl[t].e_end, tbl[t].e_done, tbl[t].e_tmo);
    end

    // Abort after the 2nd of 4 payload bits
    load_frame(14, 4, 16'h000B);
    begin_frame(4);
    chk("guard.state", {busy, win_open}, 2'b10);
    for (int i = 0; i < 15; i++) send(smp[i], 2);
    chk("recv.state", {busy, win_open}, 2'b11);
    in_vld = 1'b1;
    in_dat = smp[15];
    strobe_cyc.push_back(cyc);
    tick();
    in_vld = 1'b0;
    abort  = 1'b1;
    tick();
    abort  = 1'b0;
    send(smp[16], 2);
    send(smp[17], 2);
    end_frame();
    chk("abort.nbits", mon_dat.size(), 2);
    if (mon_dat.size() >= 2) chk("abort.bits", {mon_dat[0], mon_dat[1]}, 2'b10);
    chk("abort.nlast", mon_last.size(), 0);
    chk("abort.ndone", mon_done.size(), 0);
    chk("abort.ntmo", mon_tmo.size(), 0);
    chk("abort.idle", {busy, win_open}, 2'b00);

    // A start right after the abort is accepted normally
    load_frame(14, 4, 16'h000B);
    exp_q = '{1'b1, 1'b0, 1'b1, 1'b1};
    run_frame(4, 20, 2);
    check_frame("after_abort", 18, 1'b1, 1'b0);

    // start with a new rx_len during HUNT is ignored
    load_frame(14, 4, 16'h000B);
    begin_frame(4);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        start  = 1'b1;
        rx_len = LEN_W'(2);
        tick();
        start  = 1'b0;
      end
      send(smp[i], 2);
    end
    end_frame();
    exp_q = '{1'b1, 1'b0, 1'b1, 1'b1};
    check_frame("start_in_hunt", 18, 1'b1, 1'b0);

    // rst mid-HUNT with the first half of a preamble already shifted in
    load_frame(14, 4, 16'h000B);
    begin_frame(4);
    for (int i = 0; i < 11; i++) send(smp[i], 2);
    chk("hunt.state", {busy, win_open}, 2'b11);
    rst = 1'b1;
    tick();
    chk("midrst.outputs", {busy, win_open, bit_dat, bit_vld, bit_last, done, timeout}, 7'b0);
    rst = 1'b0;
    tick();
    smp.delete();
    for (int i = 0; i < SMP_MAX; i++) smp.push_back(1'b0);
    smp[8]  = 1'b1;  // remaining 3 preamble samples: 1,0,0
    smp[11] = 1'b1;  // then payload-like 1011
    smp[13] = 1'b1;
    smp[14] = 1'b1;
    exp_q.delete();
    run_frame(4, 202, 2);
    check_frame("after_rst", 200, 1'b0, 1'b1);

    // Randomized frames against the reference model
    for (int r = 0; r < 20; r++) begin
      len  = $urandom_range(0, 12);
      gap  = $urandom_range(2, 4);
      dens = $urandom_range(0, 2);
      smp.delete();
      for (int i = 0; i < SMP_MAX; i++) begin
        b = (dens == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
        smp.push_back(b);
      end
      if ($urandom_range(0, 3) != 0) begin
        p = $urandom_range(GUARD_SMP + 1, TIMEOUT_SMP + 3);
        for (int j = 0; j < PRE_LEN; j++) smp[p - PRE_LEN + j] = PREAMBLE[PRE_LEN-1-j];
      end
      model(len, e_end, e_done, e_tmo);
      run_frame(len, e_end + 2, gap);
      check_frame($sformatf("rnd%0d", r), e_end, e_done, e_tmo);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_rx_window_ctrl
`default_nettype wire
